// File: rtl/inst_encoder_pkg.sv
// Shared instruction-word layout, common to the decoder and this encoder.
// Holds the field widths, the bit position of every field in the 32-bit word,
// and the op_msb threshold that selects the derived encoding.
package inst_encoder_pkg;

    localparam int WORD       = 32;
    localparam int HALF       = 16;
    localparam int REGADDR    = 4;
    localparam int ALU_OPCODE = 8;

    localparam int OP_MSB_HI   = 31;
    localparam int OP_MSB_LO   = 28;
    localparam int RD_HI       = 27;
    localparam int RD_LO       = 24;
    localparam int RS_HI       = 23;
    localparam int RS_LO       = 20;
    localparam int ISFLOAT_BIT = 19;
    localparam int SRC_BIT     = 18;
    localparam int DST_HI      = 17;
    localparam int DST_LO      = 16;
    localparam int IMM_HI      = 15;
    localparam int IMM_LO      = 0;
    localparam int OPLSB_HI    = 15;
    localparam int OPLSB_LO    = 12;

    // op_msb at or above this value, with src=1, selects the derived form
    localparam logic [3:0] OP_DERIVED_MIN = 4'd9;

endpackage

// File: rtl/inst_fifo.sv
// DEPTH x WORD synchronous FIFO holding packed instruction words.
// Ports: clk, rst (async, active high), push/push_data, pop,
//        head (word at the read pointer), level (occupied entries).
// Push into a full FIFO and pop from an empty one are ignored.
module inst_fifo
    import inst_encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WORD-1:0]          push_data,
    input  logic                     pop,
    output logic [WORD-1:0]          head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WORD-1:0]  mem_q [DEPTH];
    logic [WORD-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign do_push = push && (level_q != LVL_W'(DEPTH));
    assign do_pop  = pop && (level_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);   // DEPTH is a power of two
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: packs decoded fields into 32-bit instruction words,
// buffers them in inst_fifo and streams them to instruction memory.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_*                field set with valid/ready handshake
//   base_load/base_addr load the write address
//   mem_we/addr/wdata   memory write port, mem_ready is backpressure
//   lossy_err/err_clr   sticky flag for encodings that clobbered imm bits
//   fifo_level          occupied FIFO entries
//   words_written       completed memory writes (wraps)
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_opcode,
    input  logic [3:0]              in_rd,
    input  logic [3:0]              in_rs,
    input  logic                    in_isfloat,
    input  logic                    in_src,
    input  logic [1:0]              in_dst,
    input  logic [15:0]             in_imm,
    input  logic                    base_load,
    input  logic [ADDR_W-1:0]       base_addr,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_ready,
    output logic                    lossy_err,
    input  logic                    err_clr,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [15:0]             words_written
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [3:0]        op_msb, op_lsb;
    logic              derived;
    logic              lossy_hit;
    logic [WORD-1:0]   packed_word;
    logic              push, pop;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       words_written_q, words_written_d;
    logic              lossy_q, lossy_d;

    // Field packing. In the lsb-carried form op_lsb rides in imm[15:12];
    // any differing imm bits there are lost, which raises lossy_err.
    always_comb begin
        op_msb  = in_opcode[7:4];
        op_lsb  = in_opcode[3:0];
        derived = (op_msb >= OP_DERIVED_MIN) && in_src;

        packed_word                      = '0;
        packed_word[OP_MSB_HI:OP_MSB_LO] = op_msb;
        packed_word[RD_HI:RD_LO]         = in_rd;
        packed_word[RS_HI:RS_LO]         = in_rs;
        packed_word[ISFLOAT_BIT]         = in_isfloat;
        packed_word[SRC_BIT]             = in_src;
        packed_word[DST_HI:DST_LO]       = in_dst;
        packed_word[IMM_HI:IMM_LO]       = in_imm;
        lossy_hit                        = 1'b0;
        if (!derived) begin
            packed_word[OPLSB_HI:OPLSB_LO] = op_lsb;
            lossy_hit = (in_imm[OPLSB_HI:OPLSB_LO] != op_lsb);
        end
    end

    // No full-bypass: a slot freed by a pop is only visible next cycle.
    assign in_ready = (fifo_level != LVL_W'(DEPTH));
    assign mem_we   = (fifo_level != '0);
    assign push     = in_valid && in_ready;
    assign pop      = mem_we && mem_ready;

    inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (packed_word),
        .pop       (pop),
        .head      (mem_wdata),
        .level     (fifo_level)
    );

    always_comb begin
        mem_addr_d      = mem_addr_q;
        words_written_d = words_written_q;
        if (pop) begin
            mem_addr_d      = mem_addr_q + ADDR_W'(1);
            words_written_d = words_written_q + 16'd1;
        end
        // base_load overrides the increment; the popped word already used the old address
        if (base_load) mem_addr_d = base_addr;
        // a lossy push on the same edge as err_clr keeps the flag set
        lossy_d = (lossy_q && !err_clr) || (push && lossy_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q      <= '0;
            words_written_q <= '0;
            lossy_q         <= 1'b0;
        end else begin
            mem_addr_q      <= mem_addr_d;
            words_written_q <= words_written_d;
            lossy_q         <= lossy_d;
        end
    end

    assign mem_addr      = mem_addr_q;
    assign words_written = words_written_q;
    assign lossy_err     = lossy_q;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Write-side counterpart of the instruction decoder: accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit instruction words.
- Buffers packed words in a small FIFO and streams them into instruction memory through a write port with backpressure and an auto-incrementing address.
- Used by the loader/test harness to build program images in the same bit layout the decoder consumes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 10, instruction memory word-address width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  field set valid
- in_ready  output  1  encoder can accept a field set
- in_opcode  input  8  ALU opcode: [7:4] op_msb, [3:0] op_lsb
- in_rd  input  4  destination register address
- in_rs  input  4  source register address
- in_isfloat  input  1  float flag
- in_src  input  1  source select
- in_dst  input  2  destination select
- in_imm  input  16  immediate
- base_load  input  1  pulse: load write address
- base_addr  input  ADDR_W  new write address
- mem_we  output  1  write request, which is also the data-valid signal
- mem_addr  output  ADDR_W  write word address
- mem_wdata  output  32  packed instruction
- mem_ready  input  1  memory accepts the write this cycle
- lossy_err  output  1  sticky: an encoding overwrote immediate bits
- err_clr  input  1  clears lossy_err
- fifo_level  output  $clog2(DEPTH)+1  occupied entries
- words_written  output  16  count of completed memory writes; wraps

Behaviour:
- Reset, asynchronous and active-high. It forces these values:
  - in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, lossy_err=0, fifo_level=0, words_written=0.
  - FIFO pointers are cleared.
  - Any write in flight is dropped.
- Packing is combinational at push time:
  - [31:28]=op_msb, [27:24]=rd, [23:20]=rs, [19]=isfloat, [18]=src, [17:16]=dst, [15:0]=imm.
  - Lsb-carried form (op_msb<=8 or src=0): bits [15:12] are replaced by op_lsb. If imm[15:12]!=op_lsb in this form, set lossy_err on the push edge.
  - Derived form (op_msb>8 and src=1): imm is passed unchanged and op_lsb is discarded. lossy_err is never set for this form.
- Push handshake:
  - in_ready = (fifo_level != DEPTH).
  - A push happens on a rising edge where in_valid && in_ready.
  - in_ready depends only on the current fill level. A pop in the same cycle does not open a slot; there is no full-bypass.
- Output side:
  - mem_we = (fifo_level != 0).
  - mem_wdata = FIFO head.
  - Pop on a rising edge where mem_we && mem_ready. On a pop:
    - mem_addr increments by 1, wrapping 2^ADDR_W-1 -> 0.
    - words_written increments by 1, wrapping 0xFFFF -> 0.
  - While mem_we=1 and mem_ready=0, mem_wdata and mem_addr hold stable.
- Latency: a word pushed at edge N is presented (mem_we=1) from edge N onward when the FIFO was empty. No combinational path from in_* to mem_*.
- Simultaneous push and pop: fifo_level is unchanged and both pointers advance. Not possible when the FIFO is empty or full.
- base_load:
  - mem_addr is set to base_addr at the next edge.
  - If a pop occurs on the same edge, that word is written at the old mem_addr, base_addr is loaded (not base_addr+1), and words_written still increments.
- err_clr:
  - Clears lossy_err at the next edge.
  - If a lossy push occurs on the same edge, set wins and lossy_err=1.
- Pointers wrap modulo DEPTH. fifo_level is the authoritative full/empty indicator.

Decomposition:
- Shared package (same as the decoder):
  - the WORD, HALF, REGADDR and ALU_OPCODE width macros;
  - field bit positions (OP_MSB_HI/LO, RD_HI/LO, RS_HI/LO, ISFLOAT_BIT, SRC_BIT, DST_HI/LO, IMM_HI/LO, OPLSB_HI/LO);
  - the threshold constant OP_DERIVED_MIN=9.
- One sub-module: inst_fifo.
  - Parameterized DEPTH x 32 synchronous FIFO with the same asynchronous reset.
  - Exposes head, level, push and pop.
- Packing and address/count logic stay in inst_encoder.

Test Plan:
- Reset mid-stream: push 3 words with mem_ready=0, then pulse rst -> mem_we=0, fifo_level=0 and in_ready=1 immediately, before the next clock edge; mem_addr=0.
- Lsb-carried pack: opcode 0x35, rd=1, rs=2, isfloat=0, src=0, dst=3, imm=0x5ABC, mem_ready=1 -> mem_wdata=0x31235ABC at mem_addr 0, lossy_err stays 0.
- Derived pack: opcode 0xA7, rd=4, rs=5, src=1, dst=0, isfloat=1, imm=0x1234 -> mem_wdata=0xA45C1234, lossy_err=0.
- Lossy error: opcode 0x12, src=0, imm=0xF000 -> bits [15:12]=2, lossy_err=1. err_clr together with another lossy push -> lossy_err remains 1. err_clr alone -> lossy_err=0.
- Backpressure/full, DEPTH=4, mem_ready=0: 4 pushes -> in_ready=0, fifo_level=4, 5th field set held. Raise mem_ready -> 5 writes at consecutive addresses, in order, words_written=5.
- Base load and wrap, ADDR_W=10:
  - base_load with base_addr=0x3FF on an edge with a pop -> that word is written at the prior mem_addr, and the next word is written at 0x3FF.
  - The following word is written at 0x000.
